// File: rtl/register_file_pkg.sv
// Shared constants and types for the 32x32 register file and its write-address decoder.
package reg_file_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam logic [4:0]  ZERO_REG     = 5'd0;
  localparam int unsigned WR_COUNT_W   = 8;
  localparam logic [7:0]  WR_COUNT_MAX = 8'd255;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_file_pkg

// File: rtl/register_file_decoder.sv
// Binary-to-one-hot decoder: drives exactly one output bit high for the given index.
module Decoder #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  i_addr,
  output logic [OUT_W-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (i_addr == IN_W'(i)) o_onehot[i] = 1'b1;
    end
  end

endmodule : Decoder

// File: rtl/register_file.sv
// 32-entry register file: two combinational read ports with optional write bypass,
// one synchronous write port fed by a one-hot decoder, r0 hardwired to zero.
module register_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WORD-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [WORD-1:0]       rdata_a,
  output logic [WORD-1:0]       rdata_b,
  output logic [WR_COUNT_W-1:0] wr_count
);

  logic [NUM_REGS-1:0]   w_dec;
  logic [NUM_REGS-1:0]   w_load;
  logic [WORD-1:0]       r_regs [1:NUM_REGS-1];
  logic [WORD-1:0]       w_view [NUM_REGS];
  logic [WR_COUNT_W-1:0] r_wr_count;

  Decoder #(
    .IN_W  (REG_ADDR_W),
    .OUT_W (NUM_REGS)
  ) u_decoder (
    .i_addr   (waddr),
    .o_onehot (w_dec)
  );

  // Bit 0 is masked so a write to r0 neither stores nor counts.
  assign w_load = w_dec & {NUM_REGS{we}} & ~NUM_REGS'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (w_load[i]) r_regs[i] <= wdata;
      end
      if ((|w_load) && (r_wr_count != WR_COUNT_MAX)) r_wr_count <= r_wr_count + 1'b1;
    end
  end

  always_comb begin
    w_view[0] = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) w_view[i] = r_regs[i];
  end

  function automatic logic [WORD-1:0] f_read_port(
    input logic [REG_ADDR_W-1:0] raddr,
    input logic [WORD-1:0]       stored,
    input logic                  wr_en,
    input logic [REG_ADDR_W-1:0] wr_addr,
    input logic [WORD-1:0]       wr_data
  );
    logic hit;
    hit = BYPASS && wr_en && (wr_addr != ZERO_REG) && (raddr == wr_addr);
    if (raddr == ZERO_REG) return '0;
    if (hit)               return wr_data;
    return stored;
  endfunction

  assign rdata_a  = f_read_port(raddr_a, w_view[raddr_a], we, waddr, wdata);
  assign rdata_b  = f_read_port(raddr_b, w_view[raddr_b], we, waddr, wdata);
  assign wr_count = r_wr_count;

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench: stimulus pushes expected outputs for a bypassing and a
// non-bypassing instance; a negedge monitor pops and compares.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b, rdata_a0, rdata_b0;
  logic [7:0]  wr_count, wr_count0;

  always #5 clk = ~clk;

  register_file #(.WORD(32), .BYPASS(1'b1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .wr_count(wr_count)
  );

  register_file #(.WORD(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .rdata_a(rdata_a0), .rdata_b(rdata_b0), .wr_count(wr_count0)
  );

  typedef struct {
    string       tag;
    logic [31:0] a, b, a0, b0;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".rdata_a"},      rdata_a,          e.a);
        check({e.tag, ".rdata_b"},      rdata_b,          e.b);
        check({e.tag, ".nb.rdata_a"},   rdata_a0,         e.a0);
        check({e.tag, ".nb.rdata_b"},   rdata_b0,         e.b0);
        check({e.tag, ".wr_count"},     {24'd0, wr_count},  {24'd0, e.cnt});
        check({e.tag, ".nb.wr_count"},  {24'd0, wr_count0}, {24'd0, e.cnt});
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [4:0] ra, input bit byp,
                                         input logic w, input logic [4:0] wa,
                                         input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (byp && w && wa != 5'd0 && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  // Drives one cycle of inputs; expectations reflect state before the coming edge,
  // then the model advances to the state after that edge.
  task automatic cyc(input string tag, input logic rst, input logic w, input logic [4:0] wa,
                     input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                     input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    if (chk) begin
      e.tag = tag;
      e.a   = m_read(ra, 1'b1, w, wa, wd);
      e.b   = m_read(rb, 1'b1, w, wa, wd);
      e.a0  = m_read(ra, 1'b0, w, wa, wd);
      e.b0  = m_read(rb, 1'b0, w, wa, wd);
      e.cnt = 8'(m_cnt);
      q.push_back(e);
    end
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0;
    end else if (w && wa != 5'd0) begin
      m_regs[wa] = wd;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  initial begin : stimulus
    int budget;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 0;

    cyc("rst0", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    cyc("rst1", 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 32; i++)
      cyc("rstsweep", 1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1);

    cyc("wr5",     1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1);
    cyc("rd5",     1'b1, 1'b0, 5'd0, 32'd0,        5'd5, 5'd0, 1'b1);
    cyc("wr0",     1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);
    cyc("rd0",     1'b1, 1'b0, 5'd0, 32'd0,        5'd0, 5'd5, 1'b1);
    cyc("byp7",    1'b1, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b1);
    cyc("rd7",     1'b1, 1'b0, 5'd0, 32'd0,        5'd7, 5'd7, 1'b1);
    cyc("wr3",     1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5, 1'b1);
    cyc("rstwr3",  1'b0, 1'b1, 5'd3, 32'h00000001, 5'd3, 5'd3, 1'b1);
    cyc("rd3",     1'b1, 1'b0, 5'd0, 32'd0,        5'd3, 5'd5, 1'b1);
    cyc("b2b9a",   1'b1, 1'b1, 5'd9, 32'h00000001, 5'd9, 5'd1, 1'b1);
    cyc("b2b9b",   1'b1, 1'b1, 5'd9, 32'h00000002, 5'd9, 5'd9, 1'b1);
    cyc("rd9",     1'b1, 1'b0, 5'd0, 32'd0,        5'd9, 5'd9, 1'b1);

    for (int i = 1; i < 32; i++)
      cyc("sweepwr", 1'b1, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(i - 1), 1'b1);
    for (int i = 0; i < 32; i++)
      cyc("sweeprd", 1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(i), 1'b1);

    for (int i = 0; i < 300; i++)
      cyc("sat", 1'b1, 1'b1, 5'((i % 31) + 1), 32'hC0DE0000 + 32'(i), 5'(i % 32), 5'd31, 1'b1);
    for (int i = 0; i < 4; i++)
      cyc("satrd", 1'b1, 1'b0, 5'd0, 32'd0, 5'(i * 8 + 1), 5'(i * 8 + 2), 1'b1);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Thirty-two-entry, 32-bit general-purpose register file for the single-cycle datapath. It sits directly downstream of the 5-to-32 one-hot write-address decoder, and consumes that decoder's output as per-register write enables. It provides two combinational read ports for the operand-fetch stage and one synchronous write port for write-back. Register 0 is hardwired to zero.

## Interface
Parameters:
- WORD, 32, data width of each register and of every data port
- BYPASS, 1, 1 = same-cycle write-to-read forwarding on both read ports; 0 = no forwarding

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous and active-low; sampled on the clk rising edge
- we  input  1  write enable for the write-back port
- waddr  input  5  write register index; decoded one-hot to 32 enables
- wdata  input  WORD  write data
- raddr_a  input  5  read port A index
- raddr_b  input  5  read port B index
- rdata_a  output  WORD  read port A data, combinational
- rdata_b  output  WORD  read port B data, combinational
- wr_count  output  8  saturating count of committed writes to registers 1..31; diagnostic

## Operation
- Storage: registers r1..r31, each WORD bits. r0 has no storage and always reads 0.
- Write enables: waddr feeds the one-hot decoder, giving en[31:0]. Register i loads wdata at the edge when rst_n=1, we=1 and en[i]=1, for i≠0.
- Write to r0: discarded. No state change and no wr_count increment.
- Read: rdata_x = 0 if raddr_x=0. Otherwise rdata_x = r[raddr_x].
- Bypass (BYPASS=1): if we=1, waddr≠0 and raddr_x=waddr, rdata_x = wdata in the same cycle. Forwarding is evaluated independently for ports A and B. Both ports may hit at once.
- Bypass (BYPASS=0): a read of the register being written returns the old value until after the edge.
- wr_count: increments by 1 on each committed write to r1..r31. It holds at 255 (saturates, no wrap).
- Reset: when rst_n=0 at an edge, all registers r1..r31 and wr_count clear to 0. Reset has priority over a simultaneous write; that write is lost.

## Timing
- Write latency: wdata is visible through a non-bypassed read on the first cycle after the capturing edge.
- Read latency: 0 cycles, purely combinational from raddr_x and state (plus we/waddr/wdata when BYPASS=1).
- Reset values: every register 0, wr_count 0. Therefore rdata_a = rdata_b = 0 for any address after reset until a write commits. The exception is BYPASS=1 with we asserted during the first cycle after reset, where the bypassed wdata appears.
- Reset mid-operation: a write in the same cycle as rst_n=0 does not commit. With BYPASS=1, rdata still shows wdata combinationally during that cycle, and the value is gone after the edge.
- Back-to-back writes to the same index: the last edge wins. Each write increments wr_count.
- Simultaneous read of the same index on A and B: both ports return identical data.
- Inputs must be stable around the clk edge. There is no internal input registering.

## Structure
- Shared package reg_file_pkg:
  - NUM_REGS = 32
  - REG_ADDR_W = 5
  - ZERO_REG = 5'd0
  - WR_COUNT_W = 8
  - WR_COUNT_MAX = 8'd255
- One sub-module: the existing 5-to-32 one-hot `Decoder`, instantiated once on waddr. Its output is gated with we and with a mask for bit 0 to form the per-register load enables.
- Read muxes and bypass comparators are inline, one instance per port, generated from a common function.

## Test plan
- Reset then read: hold rst_n=0 for 2 edges, release, sweep raddr_a/raddr_b over 0..31 -> all reads 0, wr_count=0.
- Basic write/read: write r5=0xDEADBEEF, next cycle raddr_a=5, raddr_b=0 -> rdata_a=0xDEADBEEF, rdata_b=0, wr_count=1.
- r0 immutability: we=1, waddr=0, wdata=0xFFFFFFFF -> r0 reads 0 on both ports, wr_count unchanged.
- Bypass, BYPASS=1: we=1, waddr=7, wdata=0x12345678, raddr_a=raddr_b=7 in the same cycle -> both ports 0x12345678 before the edge. With BYPASS=0 -> old value 0 before the edge, 0x12345678 after.
- Reset priority: r3=0xA5A5A5A5 committed, then we=1, waddr=3, wdata=0x1 with rst_n=0 at the same edge -> after the edge r3 reads 0 and wr_count=0.
- Full sweep and saturation: write r[i]=i*0x01010101 for i=1..31, read all back -> exact match. Then perform 300 further writes -> wr_count=255 and stays at 255.
